// File: rtl/sha2_round_engine.sv
// Iterative SHA-224/SHA-256 compression engine with 1, 2 or 4 rounds per clock.
// Holds the chaining value across blocks so multi-block messages can be streamed in.
module sha2_round_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mode_i,
  input  logic         first_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  input  logic [511:0] block_i,
  output logic         digest_valid_o,
  input  logic         digest_ready_i,
  output logic [255:0] digest_o,
  output logic         busy_o
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
    $error("sha2_round_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StFinal = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [255:0] Iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] Iv224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [0:63][31:0] KRom = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // State packed as {a,b,c,d,e,f,g,h}; kw is K[t] + W[t].
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] kw);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + kw;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [255:0] h_q, h_d;
  logic [255:0] wk_q, wk_d;
  logic [511:0] w_q, w_d;
  logic [6:0]   t_q, t_d;
  logic         mode_q, mode_d;

  logic [31:0]  ext [16+R];
  logic [255:0] st [R+1];
  logic [511:0] w_next;

  // Window word 0 is W[t]; ext extends it by R freshly scheduled words.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[511-32*i -: 32];
    for (int j = 0; j < int'(R); j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    st[0] = wk_q;
    for (int r = 0; r < int'(R); r++) begin
      st[r+1] = sha_round(st[r], KRom[6'(t_q + 7'(r))] + ext[r]);
    end
    w_next = '0;
    for (int i = 0; i < 16; i++) w_next[511-32*i -: 32] = ext[i+R];
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    wk_d    = wk_q;
    w_d     = w_q;
    t_d     = t_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (block_valid_i) begin
          w_d = block_i;
          t_d = '0;
          if (first_i) begin
            mode_d = mode_i;
            h_d    = mode_i ? Iv224 : Iv256;
          end
          wk_d    = h_d;
          state_d = StRound;
        end
      end
      StRound: begin
        wk_d = st[R];
        w_d  = w_next;
        t_d  = t_q + 7'(R);
        if (t_q == 7'(64 - R)) state_d = StFinal;
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) begin
          h_d[255-32*i -: 32] = h_q[255-32*i -: 32] + wk_q[255-32*i -: 32];
        end
        state_d = StDone;
      end
      StDone: begin
        if (digest_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      h_q     <= '0;
      wk_q    <= '0;
      w_q     <= '0;
      t_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      wk_q    <= wk_d;
      w_q     <= w_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
    end
  end

  assign block_ready_o  = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign digest_valid_o = (state_q == StDone);
  assign digest_o       = {h_q[255:32], mode_q ? 32'h0 : h_q[31:0]};

endmodule

// File: tb/tb_sha2_round_engine.sv
// Scoreboard bench for sha2_round_engine: three instances with 1, 2 and 4 rounds per cycle.
module tb_sha2_round_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid [3];
  logic         first_s   [3];
  logic         mode_s    [3];
  logic         dig_ready [3];
  logic [511:0] blk       [3];
  logic         blk_ready [3];
  logic         dig_valid [3];
  logic         busy      [3];
  logic [255:0] dig       [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha2_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mode_i         (mode_s[g]),
      .first_i        (first_s[g]),
      .block_valid_i  (blk_valid[g]),
      .block_ready_o  (blk_ready[g]),
      .block_i        (blk[g]),
      .digest_valid_o (dig_valid[g]),
      .digest_ready_i (dig_ready[g]),
      .digest_o       (dig[g]),
      .busy_o         (busy[g])
    );
  end

  typedef struct {
    logic [255:0] dig;
    int           lat;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [511:0] BlkAbc   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkEmpty = {32'h80000000, 480'h0};
  localparam logic [511:0] BlkTwo1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BlkTwo2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DigAbc256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DigAbc224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] DigTwo    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DigEmpty  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n = 0;
    @(negedge clk);
    while (!blk_ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, " ready timeout"}, 256'(blk_ready[d]), 256'd1);
  endtask

  // Waits for digest_valid; k counts edges after the acceptance edge.
  task automatic wait_digest(input int d, output int k);
    k = 0;
    while (!dig_valid[d] && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic handshake(input int d, input string tag);
    dig_ready[d] = 1'b1;
    @(negedge clk);
    dig_ready[d] = 1'b0;
    check({tag, " valid drop"}, 256'(dig_valid[d]), 256'd0);
    check({tag, " ready back"}, 256'(blk_ready[d]), 256'd1);
  endtask

  task automatic run_block(input int d, input logic f, input logic m, input logic [511:0] b,
                           input logic [255:0] exp, input bit chk_dig, input string tag);
    exp_t e;
    int   k;
    sb.push_back('{dig: exp, lat: 64 / (1 << d) + 1});
    wait_ready(d, tag);
    blk_valid[d] = 1'b1;
    first_s[d]   = f;
    mode_s[d]    = m;
    blk[d]       = b;
    @(negedge clk);
    blk_valid[d] = 1'b0;
    check({tag, " busy"}, 256'(busy[d]), 256'd1);
    wait_digest(d, k);
    e = sb.pop_front();
    check({tag, " latency"}, 256'(k), 256'(e.lat));
    if (chk_dig) check({tag, " digest"}, dig[d], e.dig);
    check({tag, " ready low in DONE"}, 256'(blk_ready[d]), 256'd0);
    handshake(d, tag);
  endtask

  initial begin
    exp_t e;
    int   k;
    for (int i = 0; i < 3; i++) begin
      blk_valid[i] = 1'b0;
      first_s[i]   = 1'b0;
      mode_s[i]    = 1'b0;
      dig_ready[i] = 1'b0;
      blk[i]       = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset ready", 256'(blk_ready[i]), 256'd1);
      check("reset valid", 256'(dig_valid[i]), 256'd0);
      check("reset digest", dig[i], 256'd0);
      check("reset busy", 256'(busy[i]), 256'd0);
    end
    rst_n = 1'b1;

    run_block(0, 1'b1, 1'b0, BlkAbc, DigAbc256, 1'b1, "abc256");
    run_block(0, 1'b1, 1'b1, BlkAbc, DigAbc224, 1'b1, "abc224");
    run_block(0, 1'b1, 1'b0, BlkTwo1, 256'h0, 1'b0, "two blk1");
    run_block(0, 1'b0, 1'b1, BlkTwo2, DigTwo, 1'b1, "two blk2");
    for (int d = 0; d < 3; d++) run_block(d, 1'b1, 1'b0, BlkEmpty, DigEmpty, 1'b1, "empty");

    // Backpressure with block_valid held high throughout.
    sb.push_back('{dig: DigAbc256, lat: 65});
    wait_ready(0, "bp");
    blk_valid[0] = 1'b1;
    first_s[0]   = 1'b1;
    mode_s[0]    = 1'b0;
    blk[0]       = BlkAbc;
    @(negedge clk);
    wait_digest(0, k);
    e = sb.pop_front();
    check("bp latency", 256'(k), 256'(e.lat));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp digest stable", dig[0], e.dig);
      check("bp valid held", 256'(dig_valid[0]), 256'd1);
      check("bp ready low", 256'(blk_ready[0]), 256'd0);
    end
    sb.push_back('{dig: DigAbc256, lat: 65});
    dig_ready[0] = 1'b1;
    @(negedge clk);
    dig_ready[0] = 1'b0;
    check("bp idle after handshake", 256'(busy[0]), 256'd0);
    check("bp valid drop", 256'(dig_valid[0]), 256'd0);
    @(negedge clk);
    blk_valid[0] = 1'b0;
    check("bp reaccept", 256'(busy[0]), 256'd1);
    wait_digest(0, k);
    e = sb.pop_front();
    check("bp2 latency", 256'(k), 256'(e.lat));
    check("bp2 digest", dig[0], e.dig);
    handshake(0, "bp2");

    // Reset in the middle of a block.
    wait_ready(0, "rst");
    blk_valid[0] = 1'b1;
    first_s[0]   = 1'b1;
    mode_s[0]    = 1'b0;
    blk[0]       = BlkAbc;
    @(negedge clk);
    blk_valid[0] = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ready", 256'(blk_ready[0]), 256'd1);
    check("midrst valid", 256'(dig_valid[0]), 256'd0);
    check("midrst digest", dig[0], 256'd0);
    check("midrst busy", 256'(busy[0]), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 1'b1, 1'b0, BlkAbc, DigAbc256, 1'b1, "post-reset abc");

    check("scoreboard empty", 256'(sb.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha2_round_engine.md
Name: sha2_round_engine

Overview:
- Iterative SHA-224/SHA-256 compression engine; successor to the single-round compression datapath.
- Accepts one pre-padded 512-bit block per handshake and expands the message schedule internally.
- Runs 64 rounds with a parametrised number of rounds per cycle and a K-constant ROM, then adds the chaining value.
- Holds chaining state across blocks for multi-block messages; sits between the padding unit and the digest consumer.

Parameters:
- ROUNDS_PER_CYCLE, 1, unrolled rounds per clock. Legal values are 1, 2, 4; any other value is an elaboration error.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- mode_i  input  1  0 = SHA-256, 1 = SHA-224; sampled only at block acceptance with first_i=1
- first_i  input  1  1 = block starts a new message (load IV), 0 = continue from previous digest
- block_valid_i  input  1  block offered
- block_ready_o  output  1  engine can accept a block
- block_i  input  512  W0..W15, W0 in [511:480], big-endian words
- digest_valid_o  output  1  digest available
- digest_ready_i  input  1  consumer takes digest
- digest_o  output  256  H0 in [255:224] … H7 in [31:0]; SHA-224 mode: H0..H6 in [255:32], [31:0] forced 0
- busy_o  output  1  state is not IDLE

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; H0..H7, working regs a..h, schedule window, round counter and latched mode cleared to 0. Outputs: block_ready_o=1, digest_valid_o=0, digest_o=0, busy_o=0. Reset mid-round aborts the block with no output; the next block must use first_i=1.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: block_ready_o=1. On block_valid_i=1, accept at edge E0:
  - Load the schedule window with W0..W15 and set round counter t=0.
  - If first_i=1: latch mode_i and set H to the IV of that mode (SHA-256 IV 6a09e667…5be0cd19, SHA-224 IV c1059ed8…befa4fa4).
  - If first_i=0: keep H and the latched mode.
  - Load a..h from the selected H value in the same edge. Go to ROUND.
- ROUND: each edge applies ROUNDS_PER_CYCLE chained rounds t..t+R-1, then t += R.
  - Round function:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
    - T2 = Σ0(a) + Maj(a,b,c)
    - Σ1 = ROTR6^ROTR11^ROTR25; Σ0 = ROTR2^ROTR13^ROTR22
    - New state: a=T1+T2, e=d+T1, other regs shift.
  - All additions are modulo 2^32 and carries are discarded.
  - Schedule: for t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], with σ0 = ROTR7^ROTR18^SHR3 and σ1 = ROTR17^ROTR19^SHR10. The 16-word window shifts by R words per edge.
  - After the edge that completes round 63 (edge E(64/R)), go to FINAL.
- FINAL: one edge. Hi += working reg i (mod 2^32), set digest_valid_o=1, go to DONE.
- DONE: digest_valid_o=1 and digest_o stable until digest_ready_i=1. On that edge: digest_valid_o=0, go to IDLE. H is retained for chaining.
- Latency: digest_valid_o rises after edge E(64/R + 1) following acceptance. This is 65 edges for R=1, 33 for R=2, 17 for R=4.
- block_ready_o=0 outside IDLE; block_valid_i is ignored there.
- block_valid_i may stay high: the next block is accepted only after returning to IDLE, one edge after the digest handshake. There is no combinational ready-to-valid path.
- mode_i toggling with first_i=0 has no effect; mode stays latched per message.
- digest_o is driven from H registers. It reads the partial/previous H outside DONE; consumers rely only on DONE.

Test Plan:
- SHA-256 "abc": first_i=1, mode_i=0, block 61626380 00…00 00000018 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, digest_valid_o exactly 65 edges after acceptance (R=1).
- SHA-224 "abc": same block, mode_i=1 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, low word 00000000.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 first_i=1, block 2 first_i=0 (mode_i toggled, must be ignored) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold digest_ready_i=0 for 10 cycles with block_valid_i=1 -> digest stable, block_ready_o=0, no second acceptance until the edge after the digest handshake.
- Empty message, block 80000000 00…00, run with R=1, 2 and 4 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with latency 65, 33 and 17 respectively.
- Reset mid-round (rst_ni low at round 30) -> outputs at reset values immediately; a subsequent "abc" block produces the correct digest.
